// File: rtl/systolic_mm_array_if.sv
// Bus bundle for systolic_mm_array: K-slice input stream, C tile result, status.
// Element packing: A_in row i at [i*DATA_WIDTH +: DATA_WIDTH], B_in col j at
// [j*DATA_WIDTH +: DATA_WIDTH], C_out C[i][j] at [(i*M+j)*ACC_WIDTH +: ACC_WIDTH].
interface systolic_mm_array_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 72,
    parameter int unsigned N          = 3,
    parameter int unsigned M          = 3
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_last;
    logic [N*DATA_WIDTH-1:0]    A_in;
    logic [M*DATA_WIDTH-1:0]    B_in;
    logic                       c_valid;
    logic                       c_ready;
    logic [N*M*ACC_WIDTH-1:0]   C_out;
    logic                       busy;
    logic                       sat_flag;

    // Host side: drives beats, consumes the result tile
    modport master (
        output in_valid, in_last, A_in, B_in, c_ready,
        input  in_ready, c_valid, C_out, busy, sat_flag
    );

    // Engine side
    modport slave (
        input  in_valid, in_last, A_in, B_in, c_ready,
        output in_ready, c_valid, C_out, busy, sat_flag
    );
endinterface

// File: rtl/systolic_mm_array.sv
// Output-stationary N x M systolic matrix-multiply engine (C = A x B).
// One K-slice per beat (column of A, row of B); skewing is done internally.
// Optional feature macro: SYSTOLIC_SAT_EN -- saturating accumulators and a
// sticky sat_flag. Without it accumulators wrap and sat_flag is tied low.
module systolic_mm_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 72,
    parameter int unsigned N          = 3,
    parameter int unsigned M          = 3
) (
    input  logic                clk,
    input  logic                rst,
    systolic_mm_array_if.slave  bus
);
    localparam int unsigned PROD_WIDTH   = 2 * DATA_WIDTH;
    localparam int unsigned DRAIN_CYCLES = N + M - 1;
    localparam int unsigned CNT_WIDTH    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
`ifdef SYSTOLIC_SAT_EN
    localparam int unsigned SUM_WIDTH    = ((ACC_WIDTH > PROD_WIDTH) ? ACC_WIDTH : PROD_WIDTH) + 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_c_valid;
    logic                   r_busy;
    logic [CNT_WIDTH-1:0]   r_drain_cnt;

    logic                   w_in_fire;
    logic                   w_out_fire;

    // Operands and valids as seen by each PE, after skew and systolic forwarding
    logic [DATA_WIDTH-1:0]  w_a  [N][M];
    logic                   w_av [N][M];
    logic [DATA_WIDTH-1:0]  w_b  [N][M];
    logic                   w_bv [N][M];

    logic [N*M*ACC_WIDTH-1:0] w_acc_flat;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_c_valid & bus.c_ready;

    // Controller: tracks tile phase, owns the handshake outputs and drain timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_c_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_busy <= 1'b1;
                        if (bus.in_last) begin
                            r_state     <= S_DRAIN;
                            r_in_ready  <= 1'b0;
                            r_drain_cnt <= '0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_in_fire && bus.in_last) begin
                        r_state     <= S_DRAIN;
                        r_in_ready  <= 1'b0;
                        r_drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    // Last beat needs N+M-1 more edges to reach the far corner PE
                    if (r_drain_cnt == CNT_WIDTH'(DRAIN_CYCLES - 1)) begin
                        r_state   <= S_DONE;
                        r_c_valid <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (w_out_fire) begin
                        r_state    <= S_IDLE;
                        r_c_valid  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Row lanes: stages 0..i-1 skew row i; stages i..i+M-1 are the A pass-through
    // registers of PE(i,0..M-1), so PE(i,j) taps stage i+j.
    for (genvar i = 0; i < N; i++) begin : g_row
        localparam int unsigned DEPTH = i + M;
        logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
        logic [DEPTH-1:0]                 r_vld;

        // Shift row operand and its valid one stage per cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
                r_vld  <= '0;
            end else begin
                r_data[0] <= bus.A_in[i*DATA_WIDTH +: DATA_WIDTH];
                r_vld[0]  <= w_in_fire;
                for (int unsigned d = 1; d < DEPTH; d++) begin
                    r_data[d] <= r_data[d-1];
                    r_vld[d]  <= r_vld[d-1];
                end
            end
        end

        for (genvar j = 0; j < M; j++) begin : g_tap
            assign w_a[i][j]  = r_data[i+j];
            assign w_av[i][j] = r_vld[i+j];
        end
    end

    // Column lanes: same arrangement, PE(i,j) taps stage j+i of column j
    for (genvar j = 0; j < M; j++) begin : g_col
        localparam int unsigned DEPTH = j + N;
        logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
        logic [DEPTH-1:0]                 r_vld;

        // Shift column operand and its valid one stage per cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
                r_vld  <= '0;
            end else begin
                r_data[0] <= bus.B_in[j*DATA_WIDTH +: DATA_WIDTH];
                r_vld[0]  <= w_in_fire;
                for (int unsigned d = 1; d < DEPTH; d++) begin
                    r_data[d] <= r_data[d-1];
                    r_vld[d]  <= r_vld[d-1];
                end
            end
        end

        for (genvar i = 0; i < N; i++) begin : g_tap
            assign w_b[i][j]  = r_data[i+j];
            assign w_bv[i][j] = r_vld[i+j];
        end
    end

`ifdef SYSTOLIC_SAT_EN
    logic [N*M-1:0] w_sat_hit;
`endif

    // Processing elements: output-stationary accumulators
    for (genvar i = 0; i < N; i++) begin : g_pe_row
        for (genvar j = 0; j < M; j++) begin : g_pe_col
            logic [ACC_WIDTH-1:0]  r_acc;
            logic [PROD_WIDTH-1:0] w_prod;
            logic                  w_hit;

            assign w_prod = PROD_WIDTH'(w_a[i][j]) * PROD_WIDTH'(w_b[i][j]);
            assign w_hit  = w_av[i][j] & w_bv[i][j];

`ifdef SYSTOLIC_SAT_EN
            logic [SUM_WIDTH-1:0] w_sum;
            logic                 w_ovf;

            // Any bit above ACC_WIDTH means the true sum exceeds the accumulator range
            assign w_sum = SUM_WIDTH'(r_acc) + SUM_WIDTH'(w_prod);
            assign w_ovf = |w_sum[SUM_WIDTH-1:ACC_WIDTH];
            assign w_sat_hit[i*M+j] = w_hit & w_ovf;

            // Saturating accumulate; cleared when the tile is handed off
            always_ff @(posedge clk) begin
                if (rst || w_out_fire) begin
                    r_acc <= '0;
                end else if (w_hit) begin
                    r_acc <= w_ovf ? '1 : ACC_WIDTH'(w_sum);
                end
            end
`else
            // Wrap-around accumulate; cleared when the tile is handed off
            always_ff @(posedge clk) begin
                if (rst || w_out_fire) begin
                    r_acc <= '0;
                end else if (w_hit) begin
                    r_acc <= r_acc + ACC_WIDTH'(w_prod);
                end
            end
`endif

            assign w_acc_flat[(i*M+j)*ACC_WIDTH +: ACC_WIDTH] = r_acc;
        end
    end

`ifdef SYSTOLIC_SAT_EN
    logic r_sat_flag;

    // Sticky until the tile is consumed
    always_ff @(posedge clk) begin
        if (rst || w_out_fire) begin
            r_sat_flag <= 1'b0;
        end else if (|w_sat_hit) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign bus.sat_flag = r_sat_flag;
`else
    assign bus.sat_flag = 1'b0;
`endif

    assign bus.in_ready = r_in_ready;
    assign bus.c_valid  = r_c_valid;
    assign bus.busy     = r_busy;
    assign bus.C_out    = w_acc_flat;

endmodule
